// File: rtl/display_timing_pkg.sv
// Raster timing constants for 640x480p60 and the coordinate type shared by the timing block.
// Latency: n/a (constants only). Backpressure: none.
package display_timing_pkg;

   localparam int CORDW = 10;

   localparam int H_RES  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int V_RES  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;

   localparam bit H_POL = 1'b0;
   localparam bit V_POL = 1'b0;

   function automatic int span_total(input int res, input int fp, input int sync, input int bp);
      return res + fp + sync + bp;
   endfunction

   localparam int H_TOTAL = span_total(H_RES, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_RES, V_FP, V_SYNC, V_BP);

   typedef logic [CORDW-1:0] coord_t;

endpackage

// File: rtl/display_axis_counter.sv
// One raster axis: position counter with registered sync, plus combinational wrap and next-state active.
// Latency: pos/sync registered one cycle after adv; wrap/active combinational. Backpressure: none.
module display_axis_counter
   import display_timing_pkg::*;
#(
   parameter int W          = CORDW,
   parameter int TOTAL      = H_TOTAL,
   parameter int SYNC_START = H_RES + H_FP,
   parameter int SYNC_END   = H_RES + H_FP + H_SYNC - 1,
   parameter int ACTIVE     = H_RES,
   parameter bit POL        = 1'b0
) (
   input  logic         clk_pix,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         adv,
   output logic [W-1:0] pos,
   output logic         wrap,
   output logic         sync,
   output logic         active
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);
   localparam logic [W-1:0] SS   = W'(SYNC_START);
   localparam logic [W-1:0] SE   = W'(SYNC_END);
   localparam logic [W-1:0] ACT  = W'(ACTIVE);

   logic [W-1:0] pos_next;
   logic         sync_next;

   // Holding parks the axis on its last position so the release edge wraps to 0.
   always_comb begin
      wrap      = (pos == LAST);
      pos_next  = pos;
      if (hold) begin
         pos_next = LAST;
      end else if (adv) begin
         pos_next = wrap ? '0 : pos + W'(1);
      end
      active    = !hold && (pos_next < ACT);
      sync_next = !POL;
      if (!hold && (pos_next >= SS) && (pos_next <= SE)) begin
         sync_next = POL;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         pos  <= LAST;
         sync <= !POL;
      end else begin
         pos  <= pos_next;
         sync <= sync_next;
      end
   end

endmodule

// File: rtl/display_timings_480p.sv
// 640x480p60 raster timing generator on clk_pix; optional DISPLAY_TIMINGS_FRAME_CNT_EN adds frame_cnt.
// Latency: all outputs registered from next-state, zero skew. Backpressure: none; holds while unlocked.
module display_timings_480p #(
   parameter int CORDW  = display_timing_pkg::CORDW,
   parameter int H_RES  = display_timing_pkg::H_RES,
   parameter int H_FP   = display_timing_pkg::H_FP,
   parameter int H_SYNC = display_timing_pkg::H_SYNC,
   parameter int H_BP   = display_timing_pkg::H_BP,
   parameter int V_RES  = display_timing_pkg::V_RES,
   parameter int V_FP   = display_timing_pkg::V_FP,
   parameter int V_SYNC = display_timing_pkg::V_SYNC,
   parameter int V_BP   = display_timing_pkg::V_BP,
   parameter bit H_POL  = display_timing_pkg::H_POL,
   parameter bit V_POL  = display_timing_pkg::V_POL
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             clk_pix_locked,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line,
   output logic             frame
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int H_TOTAL = display_timing_pkg::span_total(H_RES, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = display_timing_pkg::span_total(V_RES, V_FP, V_SYNC, V_BP);

   logic hold;
   logic h_wrap;
   logic h_active;
   logic v_wrap;
   logic v_active;
   logic line_next;
   logic frame_next;

   assign hold = !clk_pix_locked;

   display_axis_counter #(
      .W          (CORDW),
      .TOTAL      (H_TOTAL),
      .SYNC_START (H_RES + H_FP),
      .SYNC_END   (H_RES + H_FP + H_SYNC - 1),
      .ACTIVE     (H_RES),
      .POL        (H_POL)
   ) u_h (
      .clk_pix (clk_pix),
      .rst_n   (rst_n),
      .hold    (hold),
      .adv     (1'b1),
      .pos     (sx),
      .wrap    (h_wrap),
      .sync    (hsync),
      .active  (h_active)
   );

   // Vertical axis steps only on the horizontal wrap, so vsync spans whole lines.
   display_axis_counter #(
      .W          (CORDW),
      .TOTAL      (V_TOTAL),
      .SYNC_START (V_RES + V_FP),
      .SYNC_END   (V_RES + V_FP + V_SYNC - 1),
      .ACTIVE     (V_RES),
      .POL        (V_POL)
   ) u_v (
      .clk_pix (clk_pix),
      .rst_n   (rst_n),
      .hold    (hold),
      .adv     (h_wrap),
      .pos     (sy),
      .wrap    (v_wrap),
      .sync    (vsync),
      .active  (v_active)
   );

   // A wrap from the current position means the next position is 0 on that axis.
   always_comb begin
      line_next  = clk_pix_locked && h_wrap;
      frame_next = line_next && v_wrap;
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         de    <= 1'b0;
         line  <= 1'b0;
         frame <= 1'b0;
      end else begin
         de    <= h_active && v_active;
         line  <= line_next;
         frame <= frame_next;
      end
   end

`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         frame_cnt <= 16'd0;
      end else if (frame_next) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_display_timings_480p.sv
// Randomised lock/reset stimulus against an arithmetic raster model; scoreboard queue per DUT instance.
// A reduced-raster instance covers whole frames and vsync within a short run.
module tb_display_timings_480p;

   typedef struct packed {
      logic [9:0]  sx;
      logic [9:0]  sy;
      logic        hs;
      logic        vs;
      logic        de;
      logic        line;
      logic        frame;
      logic [15:0] fc;
   } obs_t;

   // Reduced raster: 24 x 17 = 408 cycles per frame, positive hsync.
   localparam int SH_RES = 16, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
   localparam int SV_RES = 10, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
   localparam int SH_TOT = SH_RES + SH_FP + SH_SYNC + SH_BP;
   localparam int SV_TOT = SV_RES + SV_FP + SV_SYNC + SV_BP;
   localparam int WIN    = 2 * SH_TOT * SV_TOT;

   logic clk_pix = 1'b0;
   logic rst_n = 1'b0;
   logic clk_pix_locked = 1'b0;

   logic [9:0] b_sx, b_sy, s_sx, s_sy;
   logic       b_hs, b_vs, b_de, b_line, b_frame;
   logic       s_hs, s_vs, s_de, s_line, s_frame;
   logic [15:0] b_fc, s_fc;

   always #5 clk_pix = ~clk_pix;

   display_timings_480p u_big (
      .clk_pix        (clk_pix),
      .rst_n          (rst_n),
      .clk_pix_locked (clk_pix_locked),
      .sx             (b_sx),
      .sy             (b_sy),
      .hsync          (b_hs),
      .vsync          (b_vs),
      .de             (b_de),
      .line           (b_line),
      .frame          (b_frame)
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
      ,
      .frame_cnt      (b_fc)
`endif
   );

   display_timings_480p #(
      .CORDW (10),
      .H_RES (SH_RES), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
      .V_RES (SV_RES), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
      .H_POL (1'b1),   .V_POL (1'b0)
   ) u_small (
      .clk_pix        (clk_pix),
      .rst_n          (rst_n),
      .clk_pix_locked (clk_pix_locked),
      .sx             (s_sx),
      .sy             (s_sy),
      .hsync          (s_hs),
      .vsync          (s_vs),
      .de             (s_de),
      .line           (s_line),
      .frame          (s_frame)
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
      ,
      .frame_cnt      (s_fc)
`endif
   );

`ifndef DISPLAY_TIMINGS_FRAME_CNT_EN
   assign b_fc = 16'd0;
   assign s_fc = 16'd0;
`endif

   int checks = 0;
   int failures = 0;

   obs_t q_big[$];
   obs_t q_small[$];
   bit   q_win[$];

   int s_frames = 0, s_lines = 0, s_des = 0, s_vlow = 0;
   int b_frames = 0, b_lines = 0, b_des = 0, b_hlow = 0;

   // n = cycles since the hold released (-1 while holding); position is n folded into the raster.
   function automatic obs_t model(input int n, input int hr, input int hf, input int hsw, input int hb,
                                  input int vr, input int vf, input int vsw, input int vb,
                                  input bit hp, input bit vp);
      obs_t o;
      int ht, vt, x, y;
      ht = hr + hf + hsw + hb;
      vt = vr + vf + vsw + vb;
      o = '0;
      if (n < 0) begin
         o.sx = 10'(ht - 1);
         o.sy = 10'(vt - 1);
         o.hs = !hp;
         o.vs = !vp;
         return o;
      end
      x = n % ht;
      y = (n / ht) % vt;
      o.sx    = 10'(x);
      o.sy    = 10'(y);
      o.de    = (x < hr) && (y < vr);
      o.line  = (x == 0);
      o.frame = (x == 0) && (y == 0);
      o.hs    = (x >= hr + hf && x < hr + hf + hsw) ? hp : !hp;
      o.vs    = (y >= vr + vf && y < vr + vf + vsw) ? vp : !vp;
      return o;
   endfunction

   int n_big = -1, n_small = -1;
   logic [15:0] cnt_big = 16'd0, cnt_small = 16'd0;

   task automatic step(input logic r, input logic l, input bit w);
      obs_t eb, es;
      @(negedge clk_pix);
      rst_n = r;
      clk_pix_locked = l;
      if (!r || !l) begin
         n_big = -1;
         n_small = -1;
      end else begin
         n_big++;
         n_small++;
      end
      eb = model(n_big, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      es = model(n_small, SH_RES, SH_FP, SH_SYNC, SH_BP, SV_RES, SV_FP, SV_SYNC, SV_BP, 1'b1, 1'b0);
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
      if (!r) begin
         cnt_big = 16'd0;
         cnt_small = 16'd0;
      end else begin
         if (eb.frame) cnt_big = cnt_big + 16'd1;
         if (es.frame) cnt_small = cnt_small + 16'd1;
      end
      eb.fc = cnt_big;
      es.fc = cnt_small;
`endif
      q_big.push_back(eb);
      q_small.push_back(es);
      q_win.push_back(w);
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   initial begin : monitor
      obs_t eb, es, ab, as_;
      bit w;
      forever begin
         @(posedge clk_pix);
         #1;
         if (q_big.size() > 0) begin
            eb = q_big.pop_front();
            es = q_small.pop_front();
            w  = q_win.pop_front();
            ab = {b_sx, b_sy, b_hs, b_vs, b_de, b_line, b_frame, b_fc};
            as_ = {s_sx, s_sy, s_hs, s_vs, s_de, s_line, s_frame, s_fc};
            checks++;
            if (ab !== eb) begin
               failures++;
               $display("FAIL big_obs t=%0t got sx=%0d sy=%0d hvdlf=%b%b%b%b%b fc=%0d expected sx=%0d sy=%0d hvdlf=%b%b%b%b%b fc=%0d",
                        $time, ab.sx, ab.sy, ab.hs, ab.vs, ab.de, ab.line, ab.frame, ab.fc,
                        eb.sx, eb.sy, eb.hs, eb.vs, eb.de, eb.line, eb.frame, eb.fc);
            end
            checks++;
            if (as_ !== es) begin
               failures++;
               $display("FAIL small_obs t=%0t got sx=%0d sy=%0d hvdlf=%b%b%b%b%b fc=%0d expected sx=%0d sy=%0d hvdlf=%b%b%b%b%b fc=%0d",
                        $time, as_.sx, as_.sy, as_.hs, as_.vs, as_.de, as_.line, as_.frame, as_.fc,
                        es.sx, es.sy, es.hs, es.vs, es.de, es.line, es.frame, es.fc);
            end
            if (w) begin
               s_frames += int'(s_frame);
               s_lines  += int'(s_line);
               s_des    += int'(s_de);
               s_vlow   += int'(!s_vs);
               b_frames += int'(b_frame);
               b_lines  += int'(b_line);
               b_des    += int'(b_de);
               b_hlow   += int'(!b_hs);
            end
         end
      end
   end

   initial begin : stimulus
      int drop;
      logic r, l;
      // Reset with random lock: reset must dominate.
      for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      // Two clean reduced frames, also covering line 0 and the start of line 1 at 480p.
      for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'b1);
      @(posedge clk_pix);
      #2;
      check_eq("small_frames", s_frames, 2);
      check_eq("small_lines", s_lines, 2 * SV_TOT);
      check_eq("small_de_cycles", s_des, 2 * SH_RES * SV_RES);
      check_eq("small_vsync_low", s_vlow, 2 * SV_SYNC * SH_TOT);
      check_eq("big_frames", b_frames, 1);
      check_eq("big_lines", b_lines, 2);
      check_eq("big_de_cycles", b_des, 640 + (WIN - 800));
      check_eq("big_hsync_low", b_hlow, 96);

      // Random lock drops and occasional resets.
      drop = 0;
      for (int i = 0; i < 40000; i++) begin
         r = ($urandom_range(0, 4999) != 0);
         if (drop > 0) begin
            l = 1'b0;
            drop--;
         end else if ($urandom_range(0, 799) == 0) begin
            drop = int'($urandom_range(1, 8));
            l = 1'b0;
         end else begin
            l = 1'b1;
         end
         step(r, l, 1'b0);
      end
      repeat (2) @(posedge clk_pix);
      #2;
      check_eq("queue_drained", q_big.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_timings_480p.md
Name: display_timings_480p

Overview:
- Consumer end of the pixel-clock interface. Runs on the 25.2 MHz pixel clock and its synchronised lock flag.
- Generates 640x480p60 raster timing: screen position sx/sy, hsync/vsync, data enable, line-start and frame-start strobes.
- Outputs drive the pixel-generation and TMDS-encode stages.
- All outputs are registered and describe the same pixel in the same cycle.

Parameters:
- CORDW, 10, coordinate width (sx, sy)
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- clk_pix  input  1  pixel clock
- rst_n  input  1  reset; synchronous, active-low
- clk_pix_locked  input  1  pixel clock locked, already synchronised to clk_pix
- sx  output  CORDW  horizontal position, 0..H_TOTAL-1
- sy  output  CORDW  vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity H_POL
- vsync  output  1  vertical sync, polarity V_POL
- de  output  1  data enable; high inside the active area
- line  output  1  one-cycle strobe at sx==0
- frame  output  1  one-cycle strobe at sx==0 && sy==0

Behaviour:
- Derived constants: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525). CORDW must hold H_TOTAL-1.
- Idle/hold condition: rst_n==0 or clk_pix_locked==0. Evaluated at each clk_pix edge.
- Values while holding: sx=H_TOTAL-1 (799), sy=V_TOTAL-1 (524), de=0, line=0, frame=0, hsync=~H_POL, vsync=~V_POL (inactive).
- First clock after the hold releases: sx=0, sy=0, de=1, line=1, frame=1.
- Counting: each cycle sx increments. When sx==H_TOTAL-1, sx wraps to 0 and sy advances.
- sy advance: when sy==V_TOTAL-1 at sx wrap, sy wraps to 0; otherwise sy increments.
- Output timing: next-state counters are computed combinationally, and every output is registered from those next-state values. This gives zero skew between sx/sy and hsync/vsync/de/line/frame.
- de = (sx < H_RES) && (sy < V_RES).
- hsync active for sx in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1] = 656..751.
- vsync active for sy in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1] = 490..491. vsync is a function of sy only, so it is active for whole lines.
- Lock lost mid-frame: on the next edge the block returns to the hold values, and restarts at (0,0) with a frame strobe once lock returns. No partial-frame resume.
- Reset dominates lock.
- Width arithmetic: comparisons at CORDW bits, unsigned; constants are sized to CORDW.

Optional Feature:
- Macro: DISPLAY_TIMINGS_FRAME_CNT_EN.
- Enabled: adds output port frame_cnt (16 bits).
  - Holds 0 during reset.
  - Holds its value (not cleared) while clk_pix_locked==0.
  - Increments in the same cycle frame is asserted, so it reads 1 at the first frame after reset.
  - Wraps 65535 -> 0.
- Disabled: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package display_timing_pkg holds:
  - CORDW
  - 480p constants (H_RES..V_BP, H_TOTAL, V_TOTAL, H_POL, V_POL)
  - a coord_t typedef of CORDW bits
- One natural sub-module, display_axis_counter, instantiated twice: horizontal, and vertical gated by the horizontal wrap.
  - Parameters: TOTAL, SYNC_START, SYNC_END, ACTIVE, POL.
  - Outputs: pos, wrap, sync, active.

Test Plan:
- Reset, then lock high on cycle 1 -> first edge gives sx=0, sy=0, de=1, frame=1, line=1; frame low on the next cycle.
- Free-run 800*525 = 420000 cycles -> exactly one frame strobe per 420000 cycles, 525 line strobes, 640*480 = 307200 cycles with de=1.
- Line 0 hsync check -> hsync low exactly for sx 656..751 (96 cycles) and high elsewhere.
- vsync check -> vsync low for sy 490 and 491 only (1600 cycles); de=0 for all of sy 480..524.
- Drop clk_pix_locked at sx=300, sy=200 for 5 cycles -> outputs hold at 799/524 inactive; on relock, sx=0, sy=0, frame=1.
- With DISPLAY_TIMINGS_FRAME_CNT_EN -> frame_cnt reads 1, 2, 3 at successive frame strobes; preloaded to 65535 in simulation, it wraps to 0.
